// File: rtl/mem_wb_stage.sv
// MEM stage: word-addressed data RAM (sync write, async read) plus the MEM/WB register.
// Optional macro DMEM_RANGE_CHECK_EN adds upper-address range checking and a sticky dmem_err output.
module mem_wb_stage #(
   parameter int AW = 5
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] mem_Alu_Result,
   input  logic [31:0] mem_rb,
   input  logic        mem_wmem,
   input  logic        mem_m2reg,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_rn,
   output logic [31:0] wb_Alu_Result,
   output logic [31:0] wb_mem_data,
   output logic        wb_m2reg,
   output logic        wb_wreg,
   output logic [4:0]  wb_rn,
   output logic        mem_busy
`ifdef DMEM_RANGE_CHECK_EN
   ,
   output logic        dmem_err
`endif
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {INIT, RUN} state_t;

   state_t         state;
   logic [AW-1:0]  cnt;
   logic [31:0]    ram [DEPTH];
   logic [AW-1:0]  idx;
   logic           running;
   logic           wr_en;
   logic [31:0]    rd_data;
   logic           unused_addr_bits;

   assign idx      = mem_Alu_Result[AW+1:2];
   assign running  = (state == RUN);
   assign mem_busy = (state == INIT);

`ifdef DMEM_RANGE_CHECK_EN
   logic oor;
   assign oor = (|mem_Alu_Result[31:AW+2]) & (mem_wmem | mem_m2reg);
`endif

   // Byte-offset bits never select anything; upper bits only matter with range checking.
   assign unused_addr_bits = ^{mem_Alu_Result[31:AW+2], mem_Alu_Result[1:0]};

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      rd_data = ram[idx];
      wr_en   = running & mem_wmem;
`ifdef DMEM_RANGE_CHECK_EN
      if (oor) begin
         wr_en = 1'b0;
         if (mem_m2reg) rd_data = 32'hDEADBEEF;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == {AW{1'b1}}) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // NOTE: the RAM has no reset port; the INIT sweep zeroes it one word per cycle instead.
   always_ff @(posedge clk) begin
      if (!running)   ram[cnt] <= '0;
      else if (wr_en) ram[idx] <= mem_rb;
   end

   // Instructions arriving while clearing become bubbles in the MEM/WB register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wb_Alu_Result <= '0;
         wb_mem_data   <= '0;
         wb_m2reg      <= 1'b0;
         wb_wreg       <= 1'b0;
         wb_rn         <= '0;
      end else if (!running) begin
         wb_Alu_Result <= '0;
         wb_mem_data   <= '0;
         wb_m2reg      <= 1'b0;
         wb_wreg       <= 1'b0;
         wb_rn         <= '0;
      end else begin
         wb_Alu_Result <= mem_Alu_Result;
         wb_mem_data   <= rd_data;
         wb_m2reg      <= mem_m2reg;
         wb_wreg       <= mem_wreg;
         wb_rn         <= mem_rn;
      end
   end

`ifdef DMEM_RANGE_CHECK_EN
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)              dmem_err <= 1'b0;
      else if (running && oor) dmem_err <= 1'b1;
   end
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM pipeline stage of the 5-stage CPU. Sits directly downstream of the EXE/MEM register and consumes its outputs.
- Contains a word-addressed data RAM: synchronous write, asynchronous read.
- Contains the MEM/WB pipeline register that feeds write-back and the forwarding unit.
- After reset, a clear FSM zeroes the RAM and holds mem_busy high so the hazard unit stalls the pipeline.

Parameters:
- AW, 5, RAM word-address width; DEPTH = 2^AW words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- mem_Alu_Result  in  32  ALU result from EXE/MEM; data address for loads/stores, write-back value otherwise.
- mem_rb  in  32  store data.
- mem_wmem  in  1  store enable.
- mem_m2reg  in  1  load select: write back memory data instead of the ALU result.
- mem_wreg  in  1  register-file write enable.
- mem_rn  in  5  destination register number.
- wb_Alu_Result  out  32  registered ALU result.
- wb_mem_data  out  32  registered load data.
- wb_m2reg  out  1  registered m2reg.
- wb_wreg  out  1  registered wreg.
- wb_rn  out  5  registered destination register.
- mem_busy  out  1  high while the RAM clear is in progress; the stall request to the hazard unit.

Behaviour:
- Address decode:
  - word index = mem_Alu_Result[AW+1:2].
  - bits [1:0] are ignored; misaligned addresses truncate to the word.
  - bits [31:AW+2] are ignored unless DMEM_RANGE_CHECK_EN is defined.
- FSM states:
  - INIT: clearing the RAM.
  - RUN: normal operation.
- Reset (clrn=0):
  - FSM forced to INIT; clear counter cnt (AW bits) = 0.
  - All wb_* outputs = 0; mem_busy = 1.
  - Reset asserted mid-INIT or mid-RUN restarts the clear from word 0.
  - RAM contents are not reset directly; the clear sequence zeroes them.
- INIT, each rising edge:
  - ram[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1, next state is RUN.
  - The clear takes exactly DEPTH cycles after clrn deasserts.
- mem_busy is combinational: 1 in INIT, 0 in RUN.
- In INIT, input instructions are bubbles:
  - mem_wmem is ignored; no store occurs.
  - The MEM/WB register loads all zeros, so wb_wreg = 0 and nothing is written back.
- RUN, each rising edge:
  - If mem_wmem = 1, ram[index] <= mem_rb.
  - wb_Alu_Result <= mem_Alu_Result.
  - wb_mem_data <= ram[index], the combinational read of the pre-edge contents.
  - wb_m2reg, wb_wreg, wb_rn <= mem_m2reg, mem_wreg, mem_rn.
- Latency: 1 cycle, input to wb_* outputs.
- Store followed by a load to the same word in the next cycle: the load returns the stored value, because the write commits at the store's edge.
- A store with mem_wreg = 1 is legal: both the write and the register-pipe update take place.
- wb_mem_data is captured every RUN cycle regardless of mem_m2reg; consumers qualify it with wb_m2reg.
- No internal stall: the stage advances every RUN cycle. Upstream freezing is handled before EXE/MEM.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - An access is out of range when mem_Alu_Result[31:AW+2] != 0 and (mem_wmem | mem_m2reg) = 1.
  - An out-of-range store is suppressed.
  - An out-of-range load captures wb_mem_data = 32'hDEADBEEF.
  - Adds output port dmem_err (1 bit): reset 0; set on the edge after any out-of-range access in RUN; sticky until clrn.
- Undefined:
  - Upper address bits are ignored, so accesses alias into the RAM.
  - No dmem_err port exists.

Test Plan:
- Reset release: clrn low for 2 cycles, then high → mem_busy = 1 for exactly 32 cycles (AW=5), then 0; all wb_* = 0 throughout INIT; every RAM word reads 0 afterwards.
- Store/load: store 32'h12345678 at address 0x0000_0010, next cycle load 0x10 with m2reg=1, wreg=1, rn=7 → one cycle later wb_mem_data = 32'h12345678, wb_rn = 7, wb_wreg = 1, wb_m2reg = 1.
- ALU pass-through: mem_Alu_Result = 32'hA5A5_0003, wreg=1, rn=31, no memory access → next edge wb_Alu_Result = 32'hA5A5_0003, wb_rn = 31, wb_m2reg = 0.
- INIT blocking: drive store of 32'hFFFF_FFFF to 0x4 during cycle 10 of INIT → no write (word 1 reads 0 after INIT); wb_wreg stays 0.
- Mid-operation reset: after storing 32'h55 at 0x8 in RUN, pulse clrn low → wb_* = 0 immediately (asynchronously), mem_busy = 1 for 32 cycles, then a load of 0x8 returns 0.
- With DMEM_RANGE_CHECK_EN: store 32'h77 to 0x0000_0104 → no write, dmem_err = 1 next edge and remains 1; load 0x104 → wb_mem_data = 32'hDEADBEEF; word 1 still reads 0.
